// File: rtl/common.sv
// Shared base types for the pipeline: machine word, address, fetch error codes
// and the instruction-bus request/response bundles.
package common;

  localparam int XLEN = 64;

  typedef logic [31:0]     word_t;
  typedef logic [XLEN-1:0] addr_t;

  typedef enum logic [1:0] {
    NOERROR     = 2'd0,
    EMISALIGN_I = 2'd1,
    EACCESS_I   = 2'd2
  } error_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic  ok;
    word_t data;
    logic  err;
  } ibus_resp_t;

  // addi x0,x0,0 -- placed in dataF when no real instruction was fetched
  localparam word_t NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipes.sv
// Inter-stage bundles. fetch_data_t is produced by fetch and consumed by decode.
package pipes;

  import common::*;

  typedef struct packed {
    logic   valid;
    addr_t  pc;
    word_t  instr;
    error_t error;
  } fetch_data_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer for an instruction that returned while downstream
// was stalled. Clear wins over load, load wins over unload.
module fetch_skid
  import common::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_load,
  input  logic   i_unload,
  input  logic   i_clear,
  input  addr_t  i_pc,
  input  word_t  i_instr,
  input  logic   i_err,
  output logic   o_valid,
  output addr_t  o_pc,
  output word_t  o_instr,
  output logic   o_err
);

  logic  r_valid;
  addr_t r_pc;
  word_t r_instr;
  logic  r_err;

  // occupancy flag: reset/clear empty the buffer, load fills it, unload drains it
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  // payload only changes on load; its contents are ignored while empty
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= '0;
      r_instr <= '0;
      r_err   <= 1'b0;
    end else if (i_load && !i_clear) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_err   <= i_err;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_err   = r_err;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage. Owns the PC, keeps at most one request on the
// instruction bus, parks a response in fetch_skid while decode is stalled and
// applies redirects, throwing away any response the redirect made stale.
//
// Bus handshake: ibus_valid/ibus_addr form a request that is never withdrawn;
// once ibus_valid rises it and ibus_addr stay fixed until the cycle in which
// ibus_ok is high, and that cycle also carries ibus_data/ibus_err.
module fetch
  import common::*, pipes::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          XLEN     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output fetch_data_t       dataF,
  output logic              ibus_valid,
  output logic [XLEN-1:0]   ibus_addr,
  input  logic              ibus_ok,
  input  logic [31:0]       ibus_data,
  input  logic              ibus_err,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    REQ     = 2'd0,  // request outstanding (or misaligned pc waiting to report)
    HOLD    = 2'd1,  // instruction parked in the skid buffer, bus idle
    DISCARD = 2'd2,  // stale request outstanding, its response will be dropped
    FAULT   = 2'd3   // stopped after an error until redirected
  } state_t;

  state_t          r_state, w_state_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic [XLEN-1:0] r_stale_pc, w_stale_next;
  fetch_data_t     r_data, w_data_next;

  logic       w_misaligned;
  logic       w_skid_load, w_skid_unload, w_skid_clear;
  logic       w_skid_valid, w_skid_err;
  addr_t      w_skid_pc;
  word_t      w_skid_instr;
  ibus_req_t  w_req;
  ibus_resp_t w_resp;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_resp       = '{ok: ibus_ok, data: ibus_data, err: ibus_err};
  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign w_pc_plus4   = r_pc + XLEN'(4);

  fetch_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .i_pc     (r_pc),
    .i_instr  (w_resp.data),
    .i_err    (w_resp.err),
    .o_valid  (w_skid_valid),
    .o_pc     (w_skid_pc),
    .o_instr  (w_skid_instr),
    .o_err    (w_skid_err)
  );

  // state, pc and dataF registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= REQ;
      r_pc       <= RESET_PC[XLEN-1:0];
      r_stale_pc <= '0;
      r_data     <= '{valid: 1'b0, pc: '0, instr: '0, error: NOERROR};
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_stale_pc <= w_stale_next;
      r_data     <= w_data_next;
    end
  end

  // next-state, next pc/dataF and skid controls; redirect beats stall
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_stale_next  = r_stale_pc;
    w_data_next   = r_data;
    w_skid_load   = 1'b0;
    w_skid_unload = 1'b0;
    w_skid_clear  = 1'b0;
    if (redirect) begin
      w_data_next.valid = 1'b0;
      w_skid_clear      = 1'b1;
      w_pc_next         = redirect_pc;
    end
    case (r_state)
      REQ: begin
        if (redirect) begin
          // a real request still waiting must be drained before the new one
          if (!w_misaligned && !w_resp.ok) begin
            w_stale_next = r_pc;
            w_state_next = DISCARD;
          end else begin
            w_state_next = REQ;
          end
        end else if (w_misaligned) begin
          if (!stall) begin
            w_data_next  = '{valid: 1'b1, pc: r_pc, instr: NOP_INSTR, error: EMISALIGN_I};
            w_state_next = FAULT;
          end
        end else if (w_resp.ok) begin
          w_pc_next = w_pc_plus4;
          if (stall) begin
            w_skid_load  = 1'b1;
            w_state_next = HOLD;
          end else begin
            w_data_next = '{valid: 1'b1, pc: r_pc, instr: w_resp.data,
                            error: w_resp.err ? EACCESS_I : NOERROR};
            if (w_resp.err) w_state_next = FAULT;
          end
        end else if (!stall) begin
          w_data_next.valid = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_state_next = REQ;
        end else if (!stall) begin
          w_data_next   = '{valid: w_skid_valid, pc: w_skid_pc, instr: w_skid_instr,
                            error: w_skid_err ? EACCESS_I : NOERROR};
          w_skid_unload = 1'b1;
          w_state_next  = w_skid_err ? FAULT : REQ;
        end
      end
      DISCARD: begin
        w_data_next.valid = 1'b0;
        if (w_resp.ok) w_state_next = REQ;
      end
      FAULT: begin
        if (redirect) w_state_next = REQ;
      end
      default: w_state_next = REQ;
    endcase
  end

  // bus request: only REQ with an aligned pc and DISCARD drive the bus
  always_comb begin
    w_req.valid = 1'b0;
    w_req.addr  = r_pc;
    if (!reset) begin
      if (r_state == DISCARD) begin
        w_req.valid = 1'b1;
        w_req.addr  = r_stale_pc;
      end else if (r_state == REQ && !w_misaligned) begin
        w_req.valid = 1'b1;
      end
    end
  end

  assign ibus_valid  = w_req.valid;
  assign ibus_addr   = w_req.addr;
  assign dataF       = r_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage.
module tb_fetch;

  import common::*;
  import pipes::*;

  localparam logic [1:0] S_REQ = 2'd0, S_HOLD = 2'd1, S_DISCARD = 2'd2, S_FAULT = 2'd3;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [63:0] redirect_pc;
  fetch_data_t dataF;
  logic        ibus_valid;
  logic [63:0] ibus_addr;
  logic        ibus_ok;
  logic [31:0] ibus_data;
  logic        ibus_err;
  logic [1:0]  o_dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  fetch #(.RESET_PC(64'h8000_0000), .XLEN(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dataF       (dataF),
    .ibus_valid  (ibus_valid),
    .ibus_addr   (ibus_addr),
    .ibus_ok     (ibus_ok),
    .ibus_data   (ibus_data),
    .ibus_err    (ibus_err),
    .o_dbg_state (o_dbg_state)
  );

  // driver: advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic v, input logic [63:0] pc,
                          input logic [31:0] instr, input error_t e);
    chk({tag, ".valid"}, 64'(dataF.valid), 64'(v));
    chk({tag, ".pc"},    dataF.pc, pc);
    chk({tag, ".instr"}, 64'(dataF.instr), 64'(instr));
    chk({tag, ".error"}, 64'(dataF.error), 64'(e));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ibus_ok = 1'b0; ibus_data = '0; ibus_err = 1'b0;
    #2;
    tick();
    // reset state
    chk("rst_state", 64'(o_dbg_state), 64'(S_REQ));
    chk("rst_valid", 64'(dataF.valid), 64'd0);
    chk("rst_error", 64'(dataF.error), 64'(NOERROR));
    chk("rst_ibus_valid", 64'(ibus_valid), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ibus_valid", 64'(ibus_valid), 64'd1);
    chk("post_rst_addr", ibus_addr, 64'h8000_0000);

    // zero-wait bus: one instruction per cycle
    ibus_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ibus_data = 32'hA000_0000 + 32'(i);
      tick();
      chk_data("zw", 1'b1, 64'h8000_0000 + 64'(4 * i), 32'hA000_0000 + 32'(i), NOERROR);
    end
    chk("zw_next_addr", ibus_addr, 64'h8000_000C);

    // response arrives while stalled: parked, bus idle, dataF frozen
    stall = 1'b1; ibus_data = 32'hB0B0_0001;
    tick();
    ibus_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_state", 64'(o_dbg_state), 64'(S_HOLD));
      chk("stall_ibus_valid", 64'(ibus_valid), 64'd0);
      chk_data("stall_hold", 1'b1, 64'h8000_0008, 32'hA000_0002, NOERROR);
      if (i < 2) tick();
    end
    stall = 1'b0;
    tick();
    chk_data("unload", 1'b1, 64'h8000_000C, 32'hB0B0_0001, NOERROR);
    chk("unload_state", 64'(o_dbg_state), 64'(S_REQ));
    chk("unload_addr", ibus_addr, 64'h8000_0010);
    chk("unload_ibus_valid", 64'(ibus_valid), 64'd1);

    // wait state with no stall clears dataF.valid
    tick();
    chk("wait_valid", 64'(dataF.valid), 64'd0);

    // redirect while request pending: old address held, response dropped
    redirect = 1'b1; redirect_pc = 64'h8000_1000;
    tick();
    redirect = 1'b0;
    chk("disc_state", 64'(o_dbg_state), 64'(S_DISCARD));
    chk("disc_addr", ibus_addr, 64'h8000_0010);
    chk("disc_ibus_valid", 64'(ibus_valid), 64'd1);
    tick();
    chk("disc_addr2", ibus_addr, 64'h8000_0010);
    chk("disc_valid", 64'(dataF.valid), 64'd0);
    ibus_ok = 1'b1; ibus_data = 32'hDEAD_DEAD;
    tick();
    ibus_ok = 1'b0;
    chk("disc_done_state", 64'(o_dbg_state), 64'(S_REQ));
    chk("disc_done_valid", 64'(dataF.valid), 64'd0);
    chk("disc_done_addr", ibus_addr, 64'h8000_1000);

    // redirect with simultaneous ok: straight to the target
    redirect = 1'b1; redirect_pc = 64'h8000_2000; ibus_ok = 1'b1; ibus_data = 32'hBAD0_BAD0;
    tick();
    redirect = 1'b0; ibus_ok = 1'b0;
    chk("rdok_state", 64'(o_dbg_state), 64'(S_REQ));
    chk("rdok_valid", 64'(dataF.valid), 64'd0);
    chk("rdok_addr", ibus_addr, 64'h8000_2000);
    chk("rdok_ibus_valid", 64'(ibus_valid), 64'd1);

    // redirect to a misaligned target: no bus request, NOP with EMISALIGN_I
    redirect = 1'b1; redirect_pc = 64'h8000_1002;
    tick();
    redirect = 1'b0; ibus_ok = 1'b1;
    tick();
    ibus_ok = 1'b0;
    chk("mis_req_ibus_valid", 64'(ibus_valid), 64'd0);
    chk("mis_req_valid", 64'(dataF.valid), 64'd0);
    tick();
    chk_data("mis", 1'b1, 64'h8000_1002, 32'h0000_0013, EMISALIGN_I);
    chk("mis_state", 64'(o_dbg_state), 64'(S_FAULT));
    tick(); tick();
    chk("mis_fault_hold", 64'(o_dbg_state), 64'(S_FAULT));
    chk("mis_fault_ibus_valid", 64'(ibus_valid), 64'd0);
    chk("mis_fault_dvalid", 64'(dataF.valid), 64'd1);

    // leave FAULT, then take an access fault
    redirect = 1'b1; redirect_pc = 64'h8000_3000;
    tick();
    redirect = 1'b0;
    chk("fault_exit_valid", 64'(dataF.valid), 64'd0);
    chk("fault_exit_addr", ibus_addr, 64'h8000_3000);
    ibus_ok = 1'b1; ibus_err = 1'b1; ibus_data = 32'h5555_5555;
    tick();
    ibus_ok = 1'b0; ibus_err = 1'b0;
    chk_data("acc", 1'b1, 64'h8000_3000, 32'h5555_5555, EACCESS_I);
    chk("acc_ibus_valid", 64'(ibus_valid), 64'd0);
    tick();
    chk("acc_ibus_valid2", 64'(ibus_valid), 64'd0);
    chk("acc_state", 64'(o_dbg_state), 64'(S_FAULT));

    // second redirect inside DISCARD moves pc only
    redirect = 1'b1; redirect_pc = 64'h8000_4000;
    tick();
    redirect_pc = 64'h8000_5000;
    tick();
    redirect_pc = 64'h8000_6000;
    tick();
    redirect = 1'b0;
    chk("disc2_state", 64'(o_dbg_state), 64'(S_DISCARD));
    chk("disc2_stale_addr", ibus_addr, 64'h8000_4000);
    ibus_ok = 1'b1;
    tick();
    ibus_ok = 1'b0;
    chk("disc2_new_addr", ibus_addr, 64'h8000_6000);

    // reset in the middle of DISCARD
    redirect = 1'b1; redirect_pc = 64'h8000_7000;
    tick();
    redirect = 1'b0;
    chk("pre_rst_state", 64'(o_dbg_state), 64'(S_DISCARD));
    reset = 1'b1;
    tick();
    chk("mid_rst_state", 64'(o_dbg_state), 64'(S_REQ));
    chk("mid_rst_ibus_valid", 64'(ibus_valid), 64'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_addr", ibus_addr, 64'h8000_0000);

    // pc wraps from the top of the address space
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; ibus_ok = 1'b1;
    tick();
    redirect = 1'b0; ibus_data = 32'h0BAD_F00D;
    chk("wrap_addr", ibus_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    ibus_ok = 1'b0;
    chk_data("wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0BAD_F00D, NOERROR);
    chk("wrap_next_addr", ibus_addr, 64'h0);
    chk("wrap_state", 64'(o_dbg_state), 64'(S_REQ));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
